// File: rtl/sockit_str_if.sv
// Request/grant streaming link between a word source and a word sink.
//
// Handshake: ffo_req is the source's "valid" and ffo_grt is the sink's
// "ready". ffo_bus must be stable whenever ffo_req=1. A word moves on a rising
// clock edge where ffo_req & ffo_grt are both 1. Once the sink raises
// ffo_grt it keeps it high until a word moves. The only exceptions are a
// clear or a reset.
interface sockit_str_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0] ffo_bus;
  logic          ffo_req;
  logic          ffo_grt;

  modport master (
    output ffo_bus,
    output ffo_req,
    input  ffo_grt
  );

  modport slave (
    input  ffo_bus,
    input  ffo_req,
    output ffo_grt
  );
endinterface

// File: rtl/sockit_str_sink.sv
// Receive end of the req/grt streaming link used for CDC self-test.
// The block throttles the grant with an LFSR. It checks that received words
// form an incrementing sequence modulo 2^DW. It reports run status, the
// transfer count, the error count and the position of the first mismatch.
module sockit_str_sink #(
  parameter int          DW   = 8,
  parameter int          CW   = 16,
  parameter logic [15:0] SEED = 16'hace1
) (
  input  logic          ffo_clk,
  input  logic          ffo_rst,
  sockit_str_if.slave   str,
  input  logic          ctl_ena,
  input  logic          ctl_clr,
  input  logic [15:0]   ctl_prb,
  input  logic [CW-1:0] ctl_len,
  output logic          sts_busy,
  output logic          sts_done,
  output logic          sts_fail,
  output logic [CW-1:0] sts_cnt,
  output logic [CW-1:0] sts_err,
  output logic [CW-1:0] sts_fst,
  output logic [1:0]    dbg_state,
  output logic [15:0]   dbg_lfsr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Galois feedback mask for x^16+x^14+x^13+x^11+1 in a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hb400;

  state_t        state_q, state_d;
  logic          grt_q, grt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] err_q, err_d;
  logic [CW-1:0] fst_q, fst_d;
  logic          fail_q, fail_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [15:0]   lfsr_q, lfsr_d;

  logic          xfer;
  logic          mismatch;
  logic          last_xfer;
  logic          grant_roll;
  logic [CW-1:0] cnt_inc;
  logic [15:0]   lfsr_step;

  assign xfer       = str.ffo_req & grt_q;
  // A 4-state compare makes X/Z data count as a mismatch in simulation
  assign mismatch   = (str.ffo_bus !== exp_q);
  assign cnt_inc    = cnt_q + 1'b1;
  // ctl_len is read live, so a length at or below the current count only
  // matches again after the counter wraps
  assign last_xfer  = (ctl_len != '0) && (cnt_inc == ctl_len);
  assign grant_roll = (ctl_prb == 16'hffff) || (lfsr_q < ctl_prb);
  assign lfsr_step  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

  // Next-state, grant and status update; clear overrides every other event
  always_comb begin
    state_d = state_q;
    grt_d   = grt_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fst_d   = fst_q;
    fail_d  = fail_q;
    exp_d   = exp_q;
    lfsr_d  = lfsr_q;

    // Sequence checking for any word accepted while the grant is live
    if (((state_q == S_RUN) || (state_q == S_DRAIN)) && xfer) begin
      cnt_d = cnt_inc;
      exp_d = exp_q + 1'b1;
      if (mismatch) begin
        if (err_q != '1) err_d = err_q + 1'b1;
        fail_d = 1'b1;
        if (!fail_q) fst_d = cnt_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        grt_d = 1'b0;
        if (ctl_ena) begin
          state_d = S_RUN;
          cnt_d   = '0;
          err_d   = '0;
          fst_d   = '0;
          fail_d  = 1'b0;
          exp_d   = '0;
        end
      end
      S_RUN: begin
        lfsr_d = lfsr_step;
        if (xfer && last_xfer) begin
          state_d = S_DONE;
          grt_d   = 1'b0;
        end else if (!ctl_ena) begin
          // An outstanding grant is honoured before going idle
          if (grt_q && !xfer) begin
            state_d = S_DRAIN;
            grt_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
            grt_d   = 1'b0;
          end
        end else if (!grt_q || xfer) begin
          grt_d = grant_roll;
        end else begin
          grt_d = 1'b1;
        end
      end
      S_DRAIN: begin
        grt_d = 1'b1;
        if (xfer) begin
          state_d = S_IDLE;
          grt_d   = 1'b0;
        end
      end
      S_DONE: begin
        grt_d = 1'b0;
        if (!ctl_ena) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grt_d   = 1'b0;
      end
    endcase

    if (ctl_clr) begin
      state_d = S_IDLE;
      grt_d   = 1'b0;
      cnt_d   = '0;
      err_d   = '0;
      fst_d   = '0;
      fail_d  = 1'b0;
      exp_d   = '0;
    end
  end

  // State and status registers with asynchronous active-low reset
  always_ff @(posedge ffo_clk or negedge ffo_rst) begin
    if (!ffo_rst) begin
      state_q <= S_IDLE;
      grt_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      fst_q   <= '0;
      fail_q  <= 1'b0;
      exp_q   <= '0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fst_q   <= fst_d;
      fail_q  <= fail_d;
      exp_q   <= exp_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign str.ffo_grt = grt_q;
  assign sts_busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign sts_done    = (state_q == S_DONE);
  assign sts_fail    = fail_q;
  assign sts_cnt     = cnt_q;
  assign sts_err     = err_q;
  assign sts_fst     = fst_q;
  assign dbg_state   = state_q;
  assign dbg_lfsr    = lfsr_q;

endmodule
